lifo_arb_ctrl: RTL and testbench
================================

// Module: lifo_arb_ctrl
// PURPOSE
//  Two-requester arbiter/sequencer that owns one LIFO and its status path.
//  Keeps the stack pointer and drives the single-port stack RAM (1-cycle read latency).
//  Grants one push/pop at a time, round-robin, and reports completion or rejection per requester.
//  Its pointer/empty/full outputs feed the LIFO status-signal logic (thresholds, ov/ud).
// PARAMETERS
//  DEPTH  16  stack entries; 2 <= DEPTH <= 1023
//  AW     10  pointer/address width; must hold the value DEPTH
//  DW     8   data width
// PORTS
//  clk         in   1    single clock, all logic on posedge
//  rst_n       in   1    reset; synchronous, active-low
//  req         in   2    request per requester [0],[1]; held until done/err
//  op          in   2    per requester: 1=push, 0=pop; stable while req high
//  wdata0      in   DW   push data, requester 0
//  wdata1      in   DW   push data, requester 1
//  gnt         out  2    one-hot 1-cycle grant pulse
//  done        out  2    1-cycle completion pulse to the granted requester
//  err         out  2    1-cycle rejection pulse (push when full / pop when empty)
//  rdata       out  DW   pop data; valid in the cycle done pulses, held afterwards
//  mem_we      out  1    RAM write enable
//  mem_addr    out  AW   RAM address
//  mem_wdata   out  DW   RAM write data
//  mem_rdata   in   DW   RAM read data, valid 1 cycle after mem_addr presented
//  pointer     out  AW   number of stored entries, 0..DEPTH
//  lifo_empty  out  1    pointer==0 (combinational)
//  lifo_full   out  1    pointer==DEPTH (combinational)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, pointer=0, gnt=done=err=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, rdata=0, last_gnt=1 (requester 0 wins first).
//   Reset wins over everything, including mid-operation; an in-flight op is discarded with no done/err.
//  FSM states: IDLE, EXEC, RDWAIT.
//  IDLE: if any req, pick winner round-robin: sole requester wins; both -> the one != last_gnt.
//   Registered: gnt[w]=1 for that cycle, latch op, wdata and id, last_gnt=w, go EXEC.
//  EXEC, push, !full: mem_we=1, mem_addr=pointer, mem_wdata=latched data,
//   pointer<=pointer+1, done[id]=1, go IDLE.
//  EXEC, pop, !empty: mem_addr=pointer-1, pointer<=pointer-1, go RDWAIT.
//  EXEC, push&full or pop&empty: err[id]=1, pointer and RAM untouched, go IDLE.
//  RDWAIT: rdata<=mem_rdata, done[id]=1, go IDLE.
//  Latency from gnt cycle T: push done/err at T+1; pop done at T+2, pop err at T+1.
//  Next grant no earlier than the cycle after done/err; max one op outstanding.
//  req/op changes after gnt are ignored until the op retires; the requester must drop req
//   in the cycle after done/err or it is treated as a new request.
//  Pointer never wraps: saturates by rejection at 0 and DEPTH.
//  mem_we is high only in the push EXEC cycle; gnt, done and err are mutually exclusive per cycle.
//  Full/empty use the registered pointer; no same-cycle bypass.
// TESTING
//  1 Reset then req=2'b11, op=2'b11 -> gnt=01, done[0] at T+1, pointer=1; then gnt=10 next op.
//  2 Push 0xA5 then 0x3C from req0, pop from req1 -> done[1] two cycles after gnt,
//    rdata=0x3C, pointer=1.
//  3 Pop when pointer=0 -> err pulse at T+1, mem_we=0, pointer stays 0, no done.
//  4 Fill to DEPTH=16 -> lifo_full=1; extra push -> err, pointer stays 16; pop -> lifo_full=0.
//  5 Both requesters hold req for 8 ops -> grants strictly alternate 01,10,01,...
//  6 rst_n=0 in RDWAIT -> next cycle IDLE, pointer=0, no done/err, rdata=0.

Source files
------------

// File: rtl/lifo_arb_ctrl_if.sv
// lifo_arb_ctrl_if
//   Requester-side handshake bundle for lifo_arb_ctrl.
//   req    : one request bit per requester, held until done/err
//   op     : per requester, 1 = push, 0 = pop
//   wdata0 : push data from requester 0
//   wdata1 : push data from requester 1
//   gnt    : one-hot, one-cycle grant pulse
//   done   : one-cycle completion pulse to the granted requester
//   err    : one-cycle rejection pulse (push when full / pop when empty)
//   rdata  : pop data, valid with done and held afterwards
//   master : requester side, slave : controller side
interface lifo_arb_ctrl_if #(
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    op;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [DW-1:0] rdata;

  modport master (
    output req, op, wdata0, wdata1,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, op, wdata0, wdata1,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/lifo_arb_ctrl.sv
// lifo_arb_ctrl
//   Round-robin arbiter for two requesters sharing one LIFO. Owns the stack
//   pointer and drives a single-port stack RAM with one-cycle read latency.
//   One push/pop is in flight at a time; each retires with done or err.
// Ports
//   clk        : clock, all logic on posedge
//   rst_n      : synchronous active-low reset
//   bus        : requester handshake (slave side of lifo_arb_ctrl_if)
//   mem_we     : RAM write enable (push execute cycle only)
//   mem_addr   : RAM address
//   mem_wdata  : RAM write data
//   mem_rdata  : RAM read data, valid one cycle after mem_addr
//   pointer    : number of stored entries, 0..DEPTH
//   lifo_empty : pointer == 0
//   lifo_full  : pointer == DEPTH
module lifo_arb_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  lifo_arb_ctrl_if.slave bus,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] pointer,
  output logic          lifo_empty,
  output logic          lifo_full
);

  typedef enum logic [1:0] {IDLE, EXEC, RDWAIT} state_t;

  localparam logic [AW-1:0] FULL_PTR = AW'(DEPTH);
  localparam logic [AW-1:0] ONE      = AW'(1);

  state_t        state;
  state_t        next_state;
  logic          op_r;
  logic          id_r;
  logic [DW-1:0] data_r;
  logic          last_gnt;
  logic [1:0]    grant;
  logic [1:0]    complete;
  logic [1:0]    reject;
  logic [DW-1:0] rd_data;
  logic [1:0]    eligible;
  logic          win;
  logic          op_ok;

  assign lifo_empty = (pointer == '0);
  assign lifo_full  = (pointer == FULL_PTR);

  assign bus.gnt   = grant;
  assign bus.done  = complete;
  assign bus.err   = reject;
  assign bus.rdata = rd_data;

  // A requester still sees its own done/err this cycle and only drops req
  // in the next one, so its request is masked while that pulse is high.
  assign eligible = bus.req & ~(complete | reject);

  // Sole requester wins; on contention the one not granted last time wins.
  always_comb begin
    win = 1'b0;
    if (eligible == 2'b10)      win = 1'b1;
    else if (eligible == 2'b11) win = ~last_gnt;
  end

  // Latched op can execute without rejection (registered pointer, no bypass).
  assign op_ok = op_r ? !lifo_full : !lifo_empty;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|eligible) next_state = EXEC;
      EXEC:    next_state = (!op_r && op_ok) ? RDWAIT : IDLE;
      RDWAIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: RAM port is driven only in the execute cycle, so the RAM
  // read data lands in RDWAIT, one cycle after the pop address.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == EXEC && op_ok) begin
      if (op_r) begin
        mem_we    = 1'b1;
        mem_addr  = pointer;
        mem_wdata = data_r;
      end else begin
        mem_addr  = pointer - ONE;
      end
    end
  end

  // Control: pointer, latched op/id, round-robin history and pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pointer  <= '0;
      op_r     <= 1'b0;
      id_r     <= 1'b0;
      last_gnt <= 1'b1;
      grant    <= '0;
      complete <= '0;
      reject   <= '0;
      rd_data  <= '0;
    end else begin
      grant    <= '0;
      complete <= '0;
      reject   <= '0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            grant    <= win ? 2'b10 : 2'b01;
            op_r     <= bus.op[win];
            id_r     <= win;
            last_gnt <= win;
          end
        end
        EXEC: begin
          if (!op_ok) begin
            reject[id_r] <= 1'b1;
          end else if (op_r) begin
            pointer        <= pointer + ONE;
            complete[id_r] <= 1'b1;
          end else begin
            pointer <= pointer - ONE;
          end
        end
        RDWAIT: begin
          rd_data        <= mem_rdata;
          complete[id_r] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Push data latch; only consumed after a grant, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && |eligible) data_r <= win ? bus.wdata1 : bus.wdata0;
  end

endmodule

// File: tb/tb_lifo_arb_ctrl.sv
// tb_lifo_arb_ctrl
//   Self-checking bench for lifo_arb_ctrl: a behavioural stack model fills a
//   scoreboard queue at each grant; entries are popped and compared when the
//   DUT pulses done/err. Includes a behavioural one-cycle-latency RAM.
module tb_lifo_arb_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 10;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] pointer;
  logic          lifo_empty;
  logic          lifo_full;

  always #5 clk = ~clk;

  lifo_arb_ctrl_if #(.DW(DW)) bus ();

  lifo_arb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pointer    (pointer),
    .lifo_empty (lifo_empty),
    .lifo_full  (lifo_full)
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[int'(mem_addr) % DEPTH] <= mem_wdata;
    mem_rdata <= ram[int'(mem_addr) % DEPTH];
  end

  typedef struct {
    logic [1:0]    id_oh;
    logic          is_err;
    logic          is_pop;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ptr;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] stack_m [DEPTH];
  int            ptr_m;
  logic          last_m;
  int            passed = 0;
  int            total  = 0;

  task automatic model_reset();
    ptr_m  = 0;
    last_m = 1'b1;
    sb.delete();
  endtask

  // Predict the outcome of the op granted to requester w and queue it.
  task automatic model_expect(input logic w);
    exp_t e;
    e.id_oh  = w ? 2'b10 : 2'b01;
    e.is_pop = !bus.op[w];
    e.rdata  = '0;
    e.is_err = 1'b0;
    e.lat    = 1;
    if (bus.op[w]) begin
      if (ptr_m == DEPTH) e.is_err = 1'b1;
      else begin
        stack_m[ptr_m] = w ? bus.wdata1 : bus.wdata0;
        ptr_m++;
      end
    end else begin
      if (ptr_m == 0) e.is_err = 1'b1;
      else begin
        ptr_m--;
        e.rdata = stack_m[ptr_m];
        e.lat   = 2;
      end
    end
    e.ptr = AW'(ptr_m);
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Hold req until n_ops retire; check each grant and each retirement.
  task automatic drive_ops(input logic [1:0] reqs, input int n_ops);
    int   retired = 0;
    int   cyc     = 0;
    int   gnt_cyc = 0;
    logic w;
    logic exp_we;
    exp_t e;
    bus.req = reqs;
    while (retired < n_ops && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.gnt != 2'b00) begin
        w = (reqs == 2'b11) ? ~last_m : reqs[1];
        total++;
        if (bus.gnt !== (w ? 2'b10 : 2'b01))
          $display("FAIL grant: got %b want %b", bus.gnt, (w ? 2'b10 : 2'b01));
        else passed++;
        model_expect(w);
        last_m  = w;
        gnt_cyc = cyc;
        exp_we  = bus.op[w] && !sb[$].is_err;
        total++;
        if (mem_we !== exp_we) $display("FAIL mem_we: got %b want %b", mem_we, exp_we);
        else passed++;
      end
      if ((bus.done | bus.err) != 2'b00) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_retire: got done=%b err=%b want none", bus.done, bus.err);
        end else begin
          passed++;
          e = sb.pop_front();
          total++;
          if (bus.done !== (e.is_err ? 2'b00 : e.id_oh) || bus.err !== (e.is_err ? e.id_oh : 2'b00))
            $display("FAIL retire: got done=%b err=%b want err=%b id=%b", bus.done, bus.err, e.is_err, e.id_oh);
          else passed++;
          total++;
          if (cyc - gnt_cyc != e.lat) $display("FAIL latency: got %0d want %0d", cyc - gnt_cyc, e.lat);
          else passed++;
          total++;
          if (pointer !== e.ptr) $display("FAIL pointer: got %0d want %0d", pointer, e.ptr);
          else passed++;
          if (e.is_pop && !e.is_err) begin
            total++;
            if (bus.rdata !== e.rdata) $display("FAIL rdata: got %h want %h", bus.rdata, e.rdata);
            else passed++;
          end
        end
        retired++;
      end
    end
    bus.req = 2'b00;
    total++;
    if (retired < n_ops) $display("FAIL timeout: got %0d retired want %0d", retired, n_ops);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b00) $display("FAIL idle_after: got gnt=%b want 00", bus.gnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 2'b11;
    bus.op  = 2'b11;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.gnt, bus.done, bus.err} !== 6'b0) $display("FAIL reset_pulses: got %b want 0", {bus.gnt, bus.done, bus.err});
    else passed++;
    total++;
    if (pointer !== '0 || bus.rdata !== '0) $display("FAIL reset_regs: got ptr=%0d rdata=%h want 0", pointer, bus.rdata);
    else passed++;
    total++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0)
      $display("FAIL reset_mem: got we=%b addr=%0d wdata=%h want 0", mem_we, mem_addr, mem_wdata);
    else passed++;
    total++;
    if (lifo_empty !== 1'b1 || lifo_full !== 1'b0) $display("FAIL reset_flags: got e=%b f=%b want 1 0", lifo_empty, lifo_full);
    else passed++;
    bus.req = 2'b00;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_grant();
    bus.op = 2'b11;
    bus.wdata0 = 8'h11;
    bus.wdata1 = 8'h22;
    drive_ops(2'b11, 2);
    total++;
    if (pointer !== AW'(2)) $display("FAIL first_ptr: got %0d want 2", pointer);
    else passed++;
  endtask

  task automatic test_push_pop();
    apply_reset();
    bus.op = 2'b01;
    bus.wdata0 = 8'hA5;
    drive_ops(2'b01, 1);
    bus.wdata0 = 8'h3C;
    drive_ops(2'b01, 1);
    drive_ops(2'b10, 1);
    total++;
    if (bus.rdata !== 8'h3C || pointer !== AW'(1)) $display("FAIL push_pop: got rdata=%h ptr=%0d want 3c 1", bus.rdata, pointer);
    else passed++;
  endtask

  task automatic test_pop_empty();
    bus.op = 2'b00;
    drive_ops(2'b01, 1);
    drive_ops(2'b01, 1);
    total++;
    if (lifo_empty !== 1'b1 || pointer !== '0) $display("FAIL pop_empty: got e=%b ptr=%0d want 1 0", lifo_empty, pointer);
    else passed++;
  endtask

  task automatic test_full();
    bus.op = 2'b01;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wdata0 = DW'(i * 7 + 3);
      drive_ops(2'b01, 1);
    end
    total++;
    if (lifo_full !== 1'b1 || pointer !== AW'(DEPTH)) $display("FAIL full: got f=%b ptr=%0d want 1 %0d", lifo_full, pointer, DEPTH);
    else passed++;
    bus.wdata0 = 8'hEE;
    drive_ops(2'b01, 1);
    drive_ops(2'b10, 1);
    total++;
    if (lifo_full !== 1'b0 || bus.rdata !== DW'((DEPTH - 1) * 7 + 3))
      $display("FAIL after_full_pop: got f=%b rdata=%h want 0 %h", lifo_full, bus.rdata, DW'((DEPTH - 1) * 7 + 3));
    else passed++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    bus.op = 2'b11;
    bus.wdata0 = 8'h5A;
    bus.wdata1 = 8'hC3;
    drive_ops(2'b11, 8);
    total++;
    if (pointer !== AW'(8)) $display("FAIL rr_ptr: got %0d want 8", pointer);
    else passed++;
  endtask

  task automatic test_reset_rdwait();
    logic found = 1'b0;
    bus.op = 2'b00;
    drive_ops(2'b01, 1);
    bus.req = 2'b10;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.gnt[1]) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL rdwait_gnt: got no grant want gnt[1]");
    else passed++;
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    total++;
    if (bus.done !== 2'b00 || bus.err !== 2'b00) $display("FAIL rdwait_pulse: got done=%b err=%b want 00", bus.done, bus.err);
    else passed++;
    total++;
    if (pointer !== '0 || bus.rdata !== '0) $display("FAIL rdwait_regs: got ptr=%0d rdata=%h want 0", pointer, bus.rdata);
    else passed++;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.done, bus.err} !== 6'b0) $display("FAIL rdwait_after: got %b want 0", {bus.gnt, bus.done, bus.err});
    else passed++;
    bus.op = 2'b01;
    bus.wdata0 = 8'h77;
    drive_ops(2'b01, 1);
  endtask

  initial begin
    bus.req    = 2'b00;
    bus.op     = 2'b00;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    model_reset();
    test_reset();
    test_first_grant();
    test_push_pop();
    test_pop_empty();
    test_full();
    test_round_robin();
    test_reset_rdwait();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
